// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and coefficients for simple_fir.
package fir_pkg;
  localparam int SRL_LENGTH = 27;
  localparam int NUM_PRECISION = 16;
  localparam int PROD_W = 2 * NUM_PRECISION;
  localparam int ACC_W = PROD_W + $clog2(SRL_LENGTH);
  localparam int OUT_W = 2 * NUM_PRECISION - 1;
  // Hamming-windowed sinc, fc = 0.1*fs, scaled by 0.8 before rounding so sum|h| <= 32767
  localparam logic signed [NUM_PRECISION-1:0] H [SRL_LENGTH] = '{
    16'sd49, 16'sd62, 16'sd59, 16'sd0, -16'sd152, -16'sd374, -16'sd549, -16'sd487, 16'sd0,
    16'sd983, 16'sd2339, 16'sd3759, 16'sd4839, 16'sd5243, 16'sd4839, 16'sd3759, 16'sd2339,
    16'sd983, 16'sd0, -16'sd487, -16'sd549, -16'sd374, -16'sd152, 16'sd0, 16'sd59, 16'sd62, 16'sd49
  };
  function automatic int coef_sum();
    int s = 0;
    for (int k = 0; k < SRL_LENGTH; k++) s += int'(H[k]);
    return s;
  endfunction
  localparam int DC_GAIN = coef_sum();
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: clearable shift register holding the FIR history, newest sample in taps[0].
module fir_delay_line #(
  parameter int LEN = 27,
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          data,
  output logic [LEN-1:0][W-1:0] taps
);
  always_ff @(posedge clk)
    taps <= reset ? '0 : {taps[LEN-2:0], data};
endmodule

// File: rtl/simple_fir.sv
// simple_fir: direct-form 27-tap low-pass FIR, one sample in and one full-precision result out per clock.
module simple_fir #(
  parameter int SRL_LENGTH = fir_pkg::SRL_LENGTH,
  parameter int NUM_PRECISION = fir_pkg::NUM_PRECISION
) (
  input  logic signed [NUM_PRECISION-1:0]   data,
  input  logic                              clk,
  input  logic                              reset,
  output logic signed [2*NUM_PRECISION-2:0] y
);
  import fir_pkg::*;
  logic [SRL_LENGTH-1:0][NUM_PRECISION-1:0] taps;
  logic signed [ACC_W-1:0] acc;
  fir_delay_line #(.LEN(SRL_LENGTH), .W(NUM_PRECISION)) u_line (
    .clk(clk),
    .reset(reset),
    .data(data),
    .taps(taps)
  );
  // sum|h| <= 32767 keeps the result inside OUT_W, so the top accumulator bits are pure sign
  always_comb begin
    acc = '0;
    for (int k = 0; k < SRL_LENGTH; k++)
      acc = acc + ACC_W'(PROD_W'(H[k]) * PROD_W'($signed(taps[k])));
  end
  always_ff @(posedge clk)
    y <= reset ? '0 : OUT_W'(acc);
endmodule

// File: tb/tb_simple_fir.sv
// tb_simple_fir: directed scenario tests for simple_fir against hand values and a tap-history model.
module tb_simple_fir;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [15:0] data = '0;
  logic signed [30:0] y;
  int tests = 0;
  int fails = 0;
  int h [27] = '{49, 62, 59, 0, -152, -374, -549, -487, 0, 983, 2339, 3759, 4839, 5243,
                 4839, 3759, 2339, 983, 0, -487, -549, -374, -152, 0, 59, 62, 49};
  longint hist [27];
  longint exp_y = 0;
  localparam longint DC_POS = 64'sd861739333;
  localparam longint DC_NEG = -64'sd861765632;

  simple_fir dut (.data(data), .clk(clk), .reset(reset), .y(y));

  always #5 clk = ~clk;

  task automatic tick(input logic r, input int d);
    reset = r;
    data = 16'(d);
    @(posedge clk);
    exp_y = 0;
    if (r) begin
      for (int k = 0; k < 27; k++) hist[k] = 0;
    end else begin
      for (int k = 0; k < 27; k++) exp_y += longint'(h[k]) * hist[k];
      for (int k = 26; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'(d);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 12345);
      tests++;
      if (y !== 31'sd0) begin fails++; $display("FAIL reset_hold[%0d] got %0d want 0", i, y); end
    end
    tick(1'b0, 12345);
    tests++;
    if (y !== 31'sd0) begin fails++; $display("FAIL reset_release got %0d want 0", y); end
    tick(1'b0, 0);
    tests++;
    if (y !== 31'sd604905) begin fails++; $display("FAIL reset_first_out got %0d want 604905", y); end
  endtask

  task automatic test_impulse(input string name);
    tick(1'b0, 32767);
    tests++;
    if (y !== 31'sd0) begin fails++; $display("FAIL %s_capture got %0d want 0", name, y); end
    for (int k = 0; k < 27; k++) begin
      tick(1'b0, 0);
      tests++;
      if (y !== 31'(32767 * h[k])) begin
        fails++; $display("FAIL %s[%0d] got %0d want %0d", name, k, y, 32767 * h[k]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 0);
      tests++;
      if (y !== 31'sd0) begin fails++; $display("FAIL %s_tail[%0d] got %0d want 0", name, i, y); end
    end
  endtask

  task automatic test_dc();
    tick(1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 32767);
      tests++;
      if (y !== 31'(exp_y)) begin fails++; $display("FAIL dc_pos_model[%0d] got %0d want %0d", i, y, exp_y); end
      if (i >= 30) begin
        tests++;
        if (y !== 31'(DC_POS)) begin fails++; $display("FAIL dc_pos[%0d] got %0d want %0d", i, y, DC_POS); end
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, -32768);
      tests++;
      if (y !== 31'(exp_y)) begin fails++; $display("FAIL dc_neg_model[%0d] got %0d want %0d", i, y, exp_y); end
      if (i >= 30) begin
        tests++;
        if (y !== 31'(DC_NEG)) begin fails++; $display("FAIL dc_neg[%0d] got %0d want %0d", i, y, DC_NEG); end
      end
    end
  endtask

  task automatic test_alternating();
    longint want;
    tick(1'b1, 0);
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, (i % 2 == 0) ? 32767 : -32768);
      if (i >= 30) begin
        want = (i % 2 == 1) ? 64'sd1330318 : -64'sd1356617;
        tests++;
        if (y !== 31'(want)) begin fails++; $display("FAIL alternating[%0d] got %0d want %0d", i, y, want); end
        tests++;
        if (y !== 31'(exp_y)) begin fails++; $display("FAIL alternating_model[%0d] got %0d want %0d", i, y, exp_y); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 30; i++) tick(1'b0, int'($urandom_range(0, 65535)) - 32768);
    tick(1'b1, int'($urandom_range(0, 65535)) - 32768);
    tests++;
    if (y !== 31'sd0) begin fails++; $display("FAIL midreset got %0d want 0", y); end
    test_impulse("midreset_impulse");
  endtask

  task automatic test_chirp();
    real phase = 0.0;
    real w = 0.0;
    real s;
    int d;
    longint ya;
    longint lo_max = 0;
    longint hi_max = 0;
    tick(1'b1, 0);
    for (int n = 0; n < 16000; n++) begin
      s = 32767.0 * $sin(phase);
      d = $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
      phase += w;
      w += 0.00007;
      tick(1'b0, d);
      tests++;
      if (y !== 31'(exp_y)) begin fails++; $display("FAIL chirp[%0d] got %0d want %0d", n, y, exp_y); end
      ya = longint'(y);
      if (ya < 0) ya = -ya;
      if (n >= 300 && n < 1000 && ya > lo_max) lo_max = ya;
      if (n >= 15500 && ya > hi_max) hi_max = ya;
    end
    tests++;
    if (lo_max < DC_POS * 98 / 100 || lo_max > -DC_NEG) begin
      fails++; $display("FAIL chirp_passband peak %0d want %0d..%0d", lo_max, DC_POS * 98 / 100, -DC_NEG);
    end
    tests++;
    if (hi_max > DC_POS / 100) begin
      fails++; $display("FAIL chirp_stopband peak %0d want <= %0d", hi_max, DC_POS / 100);
    end
  endtask

  initial begin
    for (int k = 0; k < 27; k++) hist[k] = 0;
    test_reset();
    tick(1'b1, 0);
    test_impulse("impulse");
    test_dc();
    test_alternating();
    test_reset_midstream();
    test_chirp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
